// File: rtl/parking_pkg.sv
// Shared types and width helpers for the parking controller and its slot FSMs.
package parking_pkg;

    typedef enum logic [1:0] {
        SLOT_FREE     = 2'b00,
        SLOT_OCCUPIED = 2'b01,
        SLOT_RESERVED = 2'b10
    } slot_state_t;

    // Width of a counter that must hold values 0..n inclusive.
    function automatic int count_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int slot_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/parking_controller_slot_ctrl.sv
// One parking slot: FREE/OCCUPIED/RESERVED state machine plus its reservation hold timer.
module slot_ctrl
    import parking_pkg::*;
#(
    parameter int HOLD_CYCLES = 750000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        occupied,
    input  logic        grant,
    input  logic        checkin_hit,
    output slot_state_t state,
    output slot_state_t state_next
);

    localparam int TIMER_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

    slot_state_t        state_reg;
    logic [TIMER_W-1:0] timer_reg;
    logic [TIMER_W-1:0] timer_next;

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        case (state_reg)
            SLOT_FREE: begin
                if (grant) begin
                    state_next = SLOT_RESERVED;
                    timer_next = TIMER_W'(HOLD_CYCLES);
                end else if (occupied) begin
                    state_next = SLOT_OCCUPIED;
                end
            end
            SLOT_OCCUPIED: begin
                if (!occupied) begin
                    state_next = SLOT_FREE;
                end
            end
            SLOT_RESERVED: begin
                // The last reserved cycle is the one where the timer reads 1.
                if (checkin_hit || (timer_reg <= TIMER_W'(1))) begin
                    state_next = SLOT_FREE;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg - TIMER_W'(1);
                end
            end
            default: begin
                state_next = SLOT_FREE;
                timer_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= SLOT_FREE;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/parking_controller.sv
// Parking lot controller: slot allocation, check-in matching and free-space accounting.
// Define PARKING_PIN_CHECK_EN to issue/check PINs; otherwise check-in uses a slot index.
module parking_controller
    import parking_pkg::*;
#(
    parameter int NUM_SLOTS   = 4,
    parameter int HOLD_CYCLES = 750000000,
    parameter int PIN_W       = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SLOTS-1:0]          occupied,
    input  logic                          gate_in,
    input  logic                          gate_out,
    input  logic                          reserve_req,
    output logic                          reserve_ack,
    output logic                          reserve_full,
    output logic [slot_w(NUM_SLOTS)-1:0]  reserve_slot,
    output logic [PIN_W-1:0]              reserve_pin,
    input  logic                          checkin_valid,
    input  logic [PIN_W-1:0]              checkin_pin,
    output logic                          checkin_ok,
    output logic                          checkin_fail,
    output logic [2*NUM_SLOTS-1:0]        slot_state,
    output logic [count_w(NUM_SLOTS)-1:0] free_count
);

    localparam int SLOT_W = slot_w(NUM_SLOTS);
    localparam int CNT_W  = count_w(NUM_SLOTS);

    slot_state_t          state_vec      [NUM_SLOTS];
    slot_state_t          state_next_vec [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] grant_vec;
    logic [NUM_SLOTS-1:0] match_vec;
    logic [NUM_SLOTS-1:0] hit_vec;
    logic [NUM_SLOTS-1:0] occ_evt;
    logic                 any_free;
    logic                 hit_found;
    logic [SLOT_W-1:0]    grant_idx;

    logic                 reserve_ack_reg;
    logic                 reserve_full_reg;
    logic [SLOT_W-1:0]    reserve_slot_reg;
    logic [PIN_W-1:0]     reserve_pin_reg;
    logic                 checkin_ok_reg;
    logic                 checkin_fail_reg;
    logic [CNT_W-1:0]     in_transit_reg;
    logic [CNT_W-1:0]     in_transit_next;
    logic [CNT_W-1:0]     free_count_reg;
    logic [CNT_W-1:0]     free_count_next;

    int                   occ_total;
    int                   transit_sum;
    int                   free_total;
    int                   avail;

`ifdef PARKING_PIN_CHECK_EN
    logic [PIN_W-1:0]     pin_gen_reg;
    logic [PIN_W-1:0]     slot_pin_reg [NUM_SLOTS];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            slot_ctrl #(
                .HOLD_CYCLES (HOLD_CYCLES)
            ) u_slot (
                .clk         (clk),
                .rst_n       (rst_n),
                .occupied    (occupied[gi]),
                .grant       (grant_vec[gi]),
                .checkin_hit (hit_vec[gi]),
                .state       (state_vec[gi]),
                .state_next  (state_next_vec[gi])
            );
            assign slot_state[2*gi +: 2] = state_vec[gi];
            // A grant wins over an arriving car on a FREE slot, so no entry event then.
            assign occ_evt[gi] = (state_vec[gi] == SLOT_FREE) && occupied[gi] && !grant_vec[gi];
        end
    endgenerate

    always_comb begin
        any_free  = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!any_free && (state_vec[i] == SLOT_FREE)) begin
                any_free     = 1'b1;
                grant_idx    = SLOT_W'(i);
                grant_vec[i] = reserve_req;
            end
        end
    end

    // Matching looks only at registered state, so a same-cycle grant can never be hit.
    always_comb begin
        match_vec = '0;
        hit_vec   = '0;
        hit_found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
`ifdef PARKING_PIN_CHECK_EN
            match_vec[i] = (state_vec[i] == SLOT_RESERVED) && (checkin_pin == slot_pin_reg[i]);
`else
            match_vec[i] = (state_vec[i] == SLOT_RESERVED) && (int'(checkin_pin) == i);
`endif
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!hit_found && match_vec[i]) begin
                hit_found  = 1'b1;
                hit_vec[i] = checkin_valid;
            end
        end
    end

    always_comb begin
        occ_total  = 0;
        free_total = 0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            occ_total = occ_total + int'(occ_evt[i]);
            if (state_next_vec[i] == SLOT_FREE) begin
                free_total = free_total + 1;
            end
        end
        transit_sum = int'(in_transit_reg) + int'(gate_in) - int'(gate_out) - occ_total;
        if (transit_sum < 0) begin
            in_transit_next = '0;
        end else if (transit_sum > NUM_SLOTS) begin
            in_transit_next = CNT_W'(NUM_SLOTS);
        end else begin
            in_transit_next = CNT_W'(transit_sum);
        end
        avail           = free_total - int'(in_transit_next);
        free_count_next = (avail < 0) ? '0 : CNT_W'(avail);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reserve_ack_reg  <= 1'b0;
            reserve_full_reg <= 1'b0;
            reserve_slot_reg <= '0;
            reserve_pin_reg  <= '0;
            checkin_ok_reg   <= 1'b0;
            checkin_fail_reg <= 1'b0;
            in_transit_reg   <= '0;
            free_count_reg   <= CNT_W'(NUM_SLOTS);
`ifdef PARKING_PIN_CHECK_EN
            pin_gen_reg      <= PIN_W'(1);
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_pin_reg[i] <= '0;
            end
`endif
        end else begin
            reserve_ack_reg  <= reserve_req && any_free;
            reserve_full_reg <= reserve_req && !any_free;
            reserve_slot_reg <= (reserve_req && any_free) ? grant_idx : '0;
            checkin_ok_reg   <= checkin_valid && hit_found;
            checkin_fail_reg <= checkin_valid && !hit_found;
            in_transit_reg   <= in_transit_next;
            free_count_reg   <= free_count_next;
`ifdef PARKING_PIN_CHECK_EN
            reserve_pin_reg  <= (reserve_req && any_free) ? pin_gen_reg : '0;
            if (reserve_req && any_free) begin
                slot_pin_reg[grant_idx] <= pin_gen_reg;
                // Zero is never issued: wrap from all-ones back to 1.
                pin_gen_reg <= (pin_gen_reg == '1) ? PIN_W'(1) : pin_gen_reg + PIN_W'(1);
            end
`else
            reserve_pin_reg  <= (reserve_req && any_free) ? PIN_W'(grant_idx) : '0;
`endif
        end
    end

    assign reserve_ack  = reserve_ack_reg;
    assign reserve_full = reserve_full_reg;
    assign reserve_slot = reserve_slot_reg;
    assign reserve_pin  = reserve_pin_reg;
    assign checkin_ok   = checkin_ok_reg;
    assign checkin_fail = checkin_fail_reg;
    assign free_count   = free_count_reg;

endmodule
